// File: rtl/sd_crc16_check.sv
// Receive-side CRC-16 checker for the SPI SD data path.
// Takes BLOCK_LEN data bytes and runs them through a bit-serial CRC-16, MSB first.
// It then captures the two CRC bytes sent by the card and reports whether they match.
module sd_crc16_check #(
  parameter int          BLOCK_LEN = 512,
  parameter logic [15:0] POLY      = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  din_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  output logic        busy_o,
  output logic [15:0] crc_calc_o,
  output logic [15:0] crc_rx_o,
  output logic        done_o,
  output logic        crc_ok_o,
  output logic        crc_err_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_D  = 3'd1,
    S_SHIFT   = 3'd2,
    S_WAIT_CH = 3'd3,
    S_WAIT_CL = 3'd4,
    S_CMP     = 3'd5
  } state_t;

  localparam logic [11:0] BLOCK_LEN_C = 12'(BLOCK_LEN);

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_rx_q, crc_rx_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic        din_ready_q, din_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        last_bit;
  logic        fb;
  logic [15:0] crc_step;
  logic [11:0] byte_cnt_inc;

  // A byte moves only when both sides agree; the ready side is registered.
  assign xfer         = din_valid_i & din_ready_q;
  assign last_bit     = (bit_cnt_q == 3'd7);
  assign byte_cnt_inc = byte_cnt_q + 12'd1;
  assign fb           = crc_q[15] ^ sh_q[7];
  assign crc_step     = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start re-arms from any state and beats a same-cycle transfer.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_WAIT_D;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_WAIT_D:  if (xfer) state_d = S_SHIFT;
        S_SHIFT:   if (last_bit) state_d = (byte_cnt_inc == BLOCK_LEN_C) ? S_WAIT_CH : S_WAIT_D;
        S_WAIT_CH: if (xfer) state_d = S_WAIT_CL;
        S_WAIT_CL: if (xfer) state_d = S_CMP;
        S_CMP:     state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values, keyed on the current state.
  always_comb begin
    crc_d       = crc_q;
    crc_rx_d    = crc_rx_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    busy_d      = busy_q;
    ok_d        = ok_q;
    err_d       = err_q;
    done_d      = 1'b0;
    din_ready_d = (state_d == S_WAIT_D) || (state_d == S_WAIT_CH) || (state_d == S_WAIT_CL);
    if (start_i) begin
      crc_d      = CRC_INIT;
      byte_cnt_d = 12'd0;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        S_WAIT_D: begin
          if (xfer) begin
            sh_d      = din_i;
            bit_cnt_d = 3'd0;
          end
        end
        S_SHIFT: begin
          crc_d     = crc_step;
          sh_d      = {sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) byte_cnt_d = byte_cnt_inc;
        end
        S_WAIT_CH: if (xfer) crc_rx_d[15:8] = din_i;
        S_WAIT_CL: if (xfer) crc_rx_d[7:0] = din_i;
        S_CMP: begin
          done_d = 1'b1;
          ok_d   = (crc_q == crc_rx_q);
          err_d  = (crc_q != crc_rx_q);
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= CRC_INIT;
      crc_rx_q    <= 16'h0000;
      sh_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 12'd0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      crc_rx_q    <= crc_rx_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign din_ready_o = din_ready_q;
  assign busy_o      = busy_q;
  assign crc_calc_o  = crc_q;
  assign crc_rx_o    = crc_rx_q;
  assign done_o      = done_q;
  assign crc_ok_o    = ok_q;
  assign crc_err_o   = err_q;

endmodule
